// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the CPU load/store path, the display scanner, Data_Memory
// and data_mem_arbiter. The arbiter uses the slave modport. The requesters and
// the memory use the master modport.
interface data_mem_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_rdata;
   logic          disp_ack;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, disp_req, disp_addr, mem_rd,
      output cpu_rdata, cpu_ack, disp_rdata, disp_ack, mem_we, mem_addr, mem_wd
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, disp_req, disp_addr, mem_rd,
      input  cpu_rdata, cpu_ack, disp_rdata, disp_ack, mem_we, mem_addr, mem_wd
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single Data_Memory port between the CPU and the
// read-only display scanner. Each access runs IDLE (arbitrate and latch),
// ACCESS (one memory cycle) and DONE (one-cycle ack).
// Build option MEM_ARB_RR_EN selects round-robin arbitration. Without it, the
// CPU has fixed priority and a starvation counter lets the display through
// after STARVE_LIMIT lost arbitrations.
// AW/DW must match the parameters of the connected interface instance.
module data_mem_arbiter #(
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   data_mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic OWN_CPU  = 1'b0;
   localparam logic OWN_DISP = 1'b1;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          we_q, we_d;
   logic          owner_q, owner_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] disp_rdata_q, disp_rdata_d;
   logic          any_req;
   logic          disp_wins;

`ifdef MEM_ARB_RR_EN
   logic          last_owner_q, last_owner_d;
`else
   localparam int unsigned       WAIT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
   logic [WAIT_W-1:0] disp_wait_q, disp_wait_d;
`endif

   assign any_req = bus.cpu_req | bus.disp_req;

   // Select the winner among the current requests
   always_comb begin
      disp_wins = 1'b0;
`ifdef MEM_ARB_RR_EN
      if (bus.cpu_req && bus.disp_req) begin
         disp_wins = (last_owner_q == OWN_CPU);
      end else begin
         disp_wins = bus.disp_req;
      end
`else
      disp_wins = bus.disp_req && (!bus.cpu_req || (disp_wait_q == WAIT_MAX));
`endif
   end

   // Next-state logic: latch the winner in IDLE, capture read data in ACCESS
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      owner_d      = owner_q;
      cpu_rdata_d  = cpu_rdata_q;
      disp_rdata_d = disp_rdata_q;
`ifdef MEM_ARB_RR_EN
      last_owner_d = last_owner_q;
`else
      disp_wait_d  = disp_wait_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = ACCESS;
               owner_d = disp_wins ? OWN_DISP : OWN_CPU;
               addr_d  = disp_wins ? bus.disp_addr : bus.cpu_addr;
               wdata_d = disp_wins ? '0 : bus.cpu_wdata;
               we_d    = !disp_wins && bus.cpu_we;
`ifdef MEM_ARB_RR_EN
               last_owner_d = disp_wins ? OWN_DISP : OWN_CPU;
`else
               if (disp_wins) begin
                  disp_wait_d = '0;
               end else if (bus.disp_req && (disp_wait_q != WAIT_MAX)) begin
                  disp_wait_d = disp_wait_q + WAIT_W'(1);
               end
`endif
            end
         end
         ACCESS: begin
            state_d = DONE;
            if (owner_q == OWN_CPU) begin
               cpu_rdata_d = bus.mem_rd;
            end else begin
               disp_rdata_d = bus.mem_rd;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and data registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         owner_q      <= OWN_DISP;
         cpu_rdata_q  <= '0;
         disp_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_owner_q <= OWN_DISP;
`else
         disp_wait_q  <= '0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         owner_q      <= owner_d;
         cpu_rdata_q  <= cpu_rdata_d;
         disp_rdata_q <= disp_rdata_d;
`ifdef MEM_ARB_RR_EN
         last_owner_q <= last_owner_d;
`else
         disp_wait_q  <= disp_wait_d;
`endif
      end
   end

   // Memory port and acks decoded from the registered state; idle outputs are zero
   always_comb begin
      bus.mem_we     = (state_q == ACCESS) && we_q && (owner_q == OWN_CPU);
      bus.mem_addr   = (state_q == ACCESS) ? addr_q  : '0;
      bus.mem_wd     = (state_q == ACCESS) ? wdata_q : '0;
      bus.cpu_ack    = (state_q == DONE) && (owner_q == OWN_CPU);
      bus.disp_ack   = (state_q == DONE) && (owner_q == OWN_DISP);
      bus.cpu_rdata  = cpu_rdata_q;
      bus.disp_rdata = disp_rdata_q;
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small word-addressed memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_data_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   rr;

   logic [31:0] mem [0:255];

   data_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

   data_mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_rd = mem[bus.mem_addr[9:2]];

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wd;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Single CPU access started from IDLE at a falling edge
   task automatic cpu_xfer(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      tick();
      chk("acc_mem_we",   {31'd0, bus.mem_we}, {31'd0, we});
      chk("acc_mem_addr", bus.mem_addr, addr);
      chk("acc_mem_wd",   bus.mem_wd, we ? wdata : 32'd0);
      chk("acc_cpu_ack",  {31'd0, bus.cpu_ack}, 32'd0);
      tick();
      chk("done_cpu_ack", {31'd0, bus.cpu_ack}, 32'd1);
      chk("done_mem_we",  {31'd0, bus.mem_we}, 32'd0);
      chk("done_mem_addr", bus.mem_addr, 32'd0);
      if (!we) chk("done_cpu_rdata", bus.cpu_rdata, exp_rd);
      bus.cpu_req = 1'b0;
      tick();
      chk("idle_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
   endtask

   initial begin
      logic first_disp;
      logic d;
`ifdef MEM_ARB_RR_EN
      rr = 1;
`else
      rr = 0;
`endif
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      rst            = 1'b1;
      bus.cpu_req    = 1'b0;
      bus.cpu_we     = 1'b0;
      bus.cpu_addr   = 32'd0;
      bus.cpu_wdata  = 32'd0;
      bus.disp_req   = 1'b0;
      bus.disp_addr  = 32'd0;
      tick();
      tick();

      // Reset values
      chk("rst_cpu_ack",    {31'd0, bus.cpu_ack}, 32'd0);
      chk("rst_disp_ack",   {31'd0, bus.disp_ack}, 32'd0);
      chk("rst_cpu_rdata",  bus.cpu_rdata, 32'd0);
      chk("rst_disp_rdata", bus.disp_rdata, 32'd0);
      chk("rst_mem_we",     {31'd0, bus.mem_we}, 32'd0);
      chk("rst_mem_addr",   bus.mem_addr, 32'd0);
      chk("rst_mem_wd",     bus.mem_wd, 32'd0);
      rst = 1'b0;
      tick();

      // CPU write, read-back, second word
      cpu_xfer(1'b1, 32'h40, 32'hDEADBEEF, 32'd0);
      cpu_xfer(1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
      cpu_xfer(1'b1, 32'h80, 32'hCAFEF00D, 32'd0);
      chk("mem_model_40", mem[16], 32'hDEADBEEF);

      // Simultaneous requests: fixed priority serves CPU first, round-robin
      // serves display first because CPU owned the last grant
      first_disp     = (rr != 0);
      bus.cpu_req    = 1'b1;
      bus.cpu_we     = 1'b0;
      bus.cpu_addr   = 32'h80;
      bus.disp_req   = 1'b1;
      bus.disp_addr  = 32'h40;
      tick();
      chk("sim1_mem_addr", bus.mem_addr, first_disp ? 32'h40 : 32'h80);
      chk("sim1_mem_we",   {31'd0, bus.mem_we}, 32'd0);
      tick();
      chk("sim1_cpu_ack",  {31'd0, bus.cpu_ack}, {31'd0, !first_disp});
      chk("sim1_disp_ack", {31'd0, bus.disp_ack}, {31'd0, first_disp});
      if (first_disp) bus.disp_req = 1'b0;
      else            bus.cpu_req  = 1'b0;
      tick();
      chk("sim_idle_acks", {30'd0, bus.cpu_ack, bus.disp_ack}, 32'd0);
      tick();
      chk("sim2_mem_addr", bus.mem_addr, first_disp ? 32'h80 : 32'h40);
      tick();
      chk("sim2_cpu_ack",  {31'd0, bus.cpu_ack}, {31'd0, first_disp});
      chk("sim2_disp_ack", {31'd0, bus.disp_ack}, {31'd0, !first_disp});
      chk("sim_cpu_rdata",  bus.cpu_rdata, 32'hCAFEF00D);
      chk("sim_disp_rdata", bus.disp_rdata, 32'hDEADBEEF);
      bus.cpu_req  = 1'b0;
      bus.disp_req = 1'b0;
      tick();

      // Both requests held for ten grants
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 32'h80;
      bus.disp_req  = 1'b1;
      bus.disp_addr = 32'h40;
      for (int g = 0; g < 10; g++) begin
         d = (rr != 0) ? (g % 2 == 0) : (g == 4 || g == 9);
         tick();
         chk($sformatf("hold%0d_mem_addr", g), bus.mem_addr, d ? 32'h40 : 32'h80);
         chk($sformatf("hold%0d_acc_acks", g), {30'd0, bus.cpu_ack, bus.disp_ack}, 32'd0);
         tick();
         chk($sformatf("hold%0d_cpu_ack", g),  {31'd0, bus.cpu_ack}, {31'd0, !d});
         chk($sformatf("hold%0d_disp_ack", g), {31'd0, bus.disp_ack}, {31'd0, d});
         chk($sformatf("hold%0d_cpu_rdata", g),  bus.cpu_rdata, 32'hCAFEF00D);
         chk($sformatf("hold%0d_disp_rdata", g), bus.disp_rdata, 32'hDEADBEEF);
`ifndef MEM_ARB_RR_EN
         if (g == 3) chk("disp_wait_sat", 32'(dut.disp_wait_q), 32'd4);
         if (g == 4) chk("disp_wait_clr", 32'(dut.disp_wait_q), 32'd0);
`endif
         tick();
         chk($sformatf("hold%0d_idle_acks", g), {30'd0, bus.cpu_ack, bus.disp_ack}, 32'd0);
      end
      bus.cpu_req  = 1'b0;
      bus.disp_req = 1'b0;
      tick();

      // Reset during ACCESS of a CPU read aborts it without an ack
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h40;
      tick();
      chk("abort_acc_addr", bus.mem_addr, 32'h40);
      rst = 1'b1;
      tick();
      chk("abort_cpu_ack",    {31'd0, bus.cpu_ack}, 32'd0);
      chk("abort_cpu_rdata",  bus.cpu_rdata, 32'd0);
      chk("abort_disp_rdata", bus.disp_rdata, 32'd0);
      chk("abort_mem_addr",   bus.mem_addr, 32'd0);
      chk("abort_mem_we",     {31'd0, bus.mem_we}, 32'd0);
      rst         = 1'b0;
      bus.cpu_req = 1'b0;
      tick();
      chk("abort_no_late_ack", {30'd0, bus.cpu_ack, bus.disp_ack}, 32'd0);
      chk("abort_idle_addr",   bus.mem_addr, 32'd0);
      tick();
      chk("abort_still_idle",  {30'd0, bus.cpu_ack, bus.disp_ack}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
